// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl : instruction-fetch sequencer (next-PC, IF/ID control,     |
// |              fetched-instruction counter)                             |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int                PWIDTH  = 16,
  parameter logic [PWIDTH-1:0] BOOT_PC = '0,
  parameter int                CWIDTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [PWIDTH-1:0] br_target_i,
  input  logic              halt_i,
  output logic [PWIDTH-1:0] next_pc_o,
  output logic              fd_en_o,
  output logic              fd_valid_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic [CWIDTH-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [PWIDTH-1:0] pc_q, pc_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              en_d, valid_d, flush_d;

  always_comb begin
    state_d = state_q;
    pc_d    = BOOT_PC;
    cnt_d   = cnt_q;
    en_d    = 1'b1;
    valid_d = 1'b0;
    flush_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (br_taken_i) begin
          pc_d    = br_target_i;
          flush_d = 1'b1;
        end else if (halt_i) begin
          pc_d    = pc_q;
          flush_d = 1'b1;
          state_d = S_HALT;
        end else if (stall_i) begin
          pc_d = pc_q;
          en_d = 1'b0;
        end else begin
          pc_d    = pc_q + 1'b1;
          valid_d = 1'b1;
          // Counter saturates rather than wrapping.
          if (cnt_q != {CWIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: begin
        pc_d = pc_q;
        if (start_i) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= BOOT_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign next_pc_o   = pc_d;
  assign fd_en_o     = en_d;
  assign fd_valid_o  = valid_d;
  assign flush_o     = flush_d;
  assign busy_o      = (state_q == S_RUN);
  assign halted_o    = (state_q == S_HALT);
  assign fetch_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_ctrl : directed + randomized bench for fetch_ctrl            |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_fetch_ctrl;

  localparam int PW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, stall = 1'b0, brt = 1'b0, halt = 1'b0;
  logic [PW-1:0] tgt = '0;
  logic [PW-1:0] next_pc;
  logic          fd_en, fd_valid, flush, busy, halted;
  logic [CW-1:0] cnt;

  fetch_ctrl #(.PWIDTH(PW), .BOOT_PC(16'h0000), .CWIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .br_taken_i(brt), .br_target_i(tgt), .halt_i(halt),
    .next_pc_o(next_pc), .fd_en_o(fd_en), .fd_valid_o(fd_valid),
    .flush_o(flush), .busy_o(busy), .halted_o(halted), .fetch_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted; pc and count as plain ints.
  int  m_mode = 0;
  int  m_pc   = 0;
  int  m_cnt  = 0;
  bit  m_init = 0;
  int  e_npc;
  bit  e_en, e_val, e_fl;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_outputs();
    e_npc = 0; e_en = 1; e_val = 0; e_fl = 0;
    if (m_mode == 1) begin
      if (brt)        begin e_npc = int'(tgt); e_fl = 1; end
      else if (halt)  begin e_npc = m_pc;      e_fl = 1; end
      else if (stall) begin e_npc = m_pc;      e_en = 0; end
      else            begin e_npc = (m_pc + 1) % 65536; e_val = 1; end
    end else if (m_mode == 2) begin
      e_npc = m_pc;
    end
  endfunction

  function automatic void model_advance();
    if (rst) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_init = 1;
    end else begin
      if (m_mode == 1 && e_val && m_cnt < (1 << CW) - 1) m_cnt++;
      m_pc = e_npc;
      if (m_mode == 0 && start)                m_mode = 1;
      else if (m_mode == 1 && !brt && halt)   m_mode = 2;
      else if (m_mode == 2 && start)          m_mode = 1;
    end
  endfunction

  // Advance one clock, apply new inputs, then compare at the falling edge.
  task automatic step(input bit r, input bit s, input bit st, input bit b,
                      input bit h, input logic [PW-1:0] t);
    @(posedge clk);
    model_advance();
    #1;
    rst = r; start = s; stall = st; brt = b; halt = h; tgt = t;
    @(negedge clk);
    if (m_init) begin
      model_outputs();
      chk("next_pc", int'(next_pc), e_npc);
      chk("fd_en", int'(fd_en), int'(e_en));
      if (e_en) chk("fd_valid", int'(fd_valid), int'(e_val));
      chk("flush", int'(flush), int'(e_fl));
      chk("busy", int'(busy), int'(m_mode == 1));
      chk("halted", int'(halted), int'(m_mode == 2));
      chk("fetch_cnt", int'(cnt), m_cnt);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    // Reset and start
    step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_idle_pc", int'(next_pc), 16'h0000);
    chk("lit_idle_busy", int'(busy), 0);
    chk("lit_idle_cnt", int'(cnt), 0);
    step(0, 1, 0, 0, 0, '0);
    chk("lit_start_pc", int'(next_pc), 16'h0000);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_run1_pc", int'(next_pc), 16'h0001);
    chk("lit_run1_valid", int'(fd_valid), 1);
    run(3);
    chk("lit_run4_pc", int'(next_pc), 16'h0004);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_cnt4", int'(cnt), 4);
    chk("lit_pc5", int'(next_pc), 16'h0005);

    // Stall three cycles at 0x0005
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, '0);
      chk("lit_stall_pc", int'(next_pc), 16'h0005);
      chk("lit_stall_en", int'(fd_en), 0);
      chk("lit_stall_cnt", int'(cnt), 5);
    end
    step(0, 0, 0, 0, 0, '0);
    chk("lit_release_pc", int'(next_pc), 16'h0006);

    // Branch beats a simultaneous stall
    step(0, 0, 0, 1, 0, 16'h0010);
    step(0, 0, 1, 1, 0, 16'h0200);
    chk("lit_br_pc", int'(next_pc), 16'h0200);
    chk("lit_br_flush", int'(flush), 1);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_tgt_pc", int'(next_pc), 16'h0201);
    chk("lit_tgt_valid", int'(fd_valid), 1);

    // Halt at 0x0031, then resume
    step(0, 0, 0, 1, 0, 16'h0031);
    step(0, 0, 0, 0, 1, '0);
    chk("lit_halt_pc", int'(next_pc), 16'h0031);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 0, 16'h0abc);
      chk("lit_halted", int'(halted), 1);
      chk("lit_halt_hold", int'(next_pc), 16'h0031);
      chk("lit_halt_valid", int'(fd_valid), 0);
    end
    step(0, 1, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_resume_pc", int'(next_pc), 16'h0032);
    chk("lit_resume_valid", int'(fd_valid), 1);

    // PC wrap and counter saturation
    step(0, 0, 0, 1, 0, 16'hffff);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_wrap0", int'(next_pc), 16'h0000);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_wrap1", int'(next_pc), 16'h0001);
    run(20);
    chk("lit_cnt_sat", int'(cnt), 4'hf);

    // Reset dominates branch and start
    step(1, 1, 0, 1, 0, 16'h1234);
    step(0, 0, 0, 0, 0, '0);
    chk("lit_rst_busy", int'(busy), 0);
    chk("lit_rst_pc", int'(next_pc), 16'h0000);
    chk("lit_rst_cnt", int'(cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 12,
           $urandom_range(99) < 20, $urandom_range(99) < 12,
           $urandom_range(99) < 6,
           ($urandom_range(3) == 0) ? 16'hffff : PW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
